// File: rtl/scmem_chan_retime_if.sv
// scmem_chan_retime_if
//   Handshake bundle for the multi-channel retiming buffer. Each vector
//   carries NCHAN channels packed side by side, with channel c in slice c.
//
//   Signals:
//     din       NCHAN*WIDTH  upstream payload
//     din_valid NCHAN        upstream valid
//     din_retry NCHAN        retry back to upstream
//     q         NCHAN*WIDTH  head payload toward downstream
//     q_valid   NCHAN        head valid
//     q_retry   NCHAN        downstream retry
//     flush     1            synchronous clear of every channel
//     occ       NCHAN*CW     occupancy per channel
//     drop_cnt  NCHAN*16     discarded-entry count per channel
//
//   Modports:
//     master  the side that drives traffic in and consumes the outputs
//     slave   the retiming buffer itself
interface scmem_chan_retime_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int NCHAN = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NCHAN*WIDTH-1:0] din;
  logic [NCHAN-1:0]       din_valid;
  logic [NCHAN-1:0]       din_retry;
  logic [NCHAN*WIDTH-1:0] q;
  logic [NCHAN-1:0]       q_valid;
  logic [NCHAN-1:0]       q_retry;
  logic                   flush;
  logic [NCHAN*CW-1:0]    occ;
  logic [NCHAN*16-1:0]    drop_cnt;

  modport master (
    output din, din_valid, q_retry, flush,
    input  din_retry, q, q_valid, occ, drop_cnt
  );

  modport slave (
    input  din, din_valid, q_retry, flush,
    output din_retry, q, q_valid, occ, drop_cnt
  );
endinterface

// File: rtl/scmem_chan_retime.sv
// scmem_chan_retime
//   NCHAN independent valid/retry retiming FIFOs, DEPTH entries each.
//   Every handshake output is decoded purely from flops, so no path exists
//   from din/din_valid/q_retry to any output. Channels selected by
//   DROP_MASK never assert retry; when full and not draining they overwrite
//   the oldest entry and bump a saturating 16-bit drop counter.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low; clears all state
//     bus    scmem_chan_retime_if.slave (payload, handshakes, flush,
//            occupancy and drop counters)
module scmem_chan_retime #(
  parameter int               WIDTH     = 64,
  parameter int               DEPTH     = 2,
  parameter int               NCHAN     = 4,
  parameter logic [NCHAN-1:0] DROP_MASK = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  scmem_chan_retime_if.slave      bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Pointer arithmetic relies on natural wrap, so DEPTH must be 2^n, n>=1.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("scmem_chan_retime: DEPTH must be a power of two >= 2");
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    localparam bit IS_DROP = DROP_MASK[c];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic [WIDTH-1:0] din_c;
    logic             full;
    logic             q_valid_c;
    logic             din_retry_c;
    logic             push;
    logic             pop;
    logic             overwrite;

    assign din_c       = bus.din[c*WIDTH +: WIDTH];
    assign full        = (count_q == CW'(DEPTH));
    assign q_valid_c   = (count_q != '0);
    assign din_retry_c = IS_DROP ? 1'b0 : full;

    assign push = bus.din_valid[c] & ~din_retry_c;
    assign pop  = q_valid_c & ~bus.q_retry[c];

    // Only reachable in drop mode: a normal channel retries when full.
    assign overwrite = full & push & ~pop;

    always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;

      if (bus.flush) begin
        // Handshakes in this cycle still complete at the interface, but
        // accepted data is discarded and the drop counter is left alone.
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) begin
          mem_d[wr_ptr_q] = din_c;
          wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop || overwrite) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (overwrite) begin
          if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else begin
          count_d = count_q + CW'(push) - CW'(pop);
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        drop_cnt_q <= '0;
      end else begin
        mem_q      <= mem_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        drop_cnt_q <= drop_cnt_d;
      end
    end

    assign bus.din_retry[c]            = din_retry_c;
    assign bus.q_valid[c]              = q_valid_c;
    assign bus.q[c*WIDTH +: WIDTH]     = q_valid_c ? mem_q[rd_ptr_q] : '0;
    assign bus.occ[c*CW +: CW]         = count_q;
    assign bus.drop_cnt[c*16 +: 16]    = drop_cnt_q;
  end
endmodule

// File: tb/tb_scmem_chan_retime.sv
module tb_scmem_chan_retime;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int N  = 4;
  localparam logic [N-1:0] DM = 4'b0100;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;

  scmem_chan_retime_if #(.WIDTH(W), .DEPTH(D), .NCHAN(N)) bus ();

  scmem_chan_retime #(
    .WIDTH(W), .DEPTH(D), .NCHAN(N), .DROP_MASK(DM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: each channel is a plain queue, head at index 0.
  typedef logic [W-1:0] q_t [$];
  q_t mq [N];
  int mdrop [N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      mdrop[c] = 0;
    end
  endtask

  // Apply the current interface inputs to the model as of the next edge.
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      logic [W-1:0] d;
      logic full, retry, push, pop;
      d     = bus.din[c*W +: W];
      full  = (mq[c].size() == D);
      retry = !DM[c] && full;
      push  = bus.din_valid[c] && !retry;
      pop   = (mq[c].size() != 0) && !bus.q_retry[c];
      if (bus.flush) begin
        mq[c].delete();
      end else begin
        if (pop) void'(mq[c].pop_front());
        if (push) begin
          if (full && !pop) begin
            void'(mq[c].pop_front());
            if (mdrop[c] < 65535) mdrop[c]++;
          end
          mq[c].push_back(d);
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic v, input logic [W-1:0] d);
    bus.din_valid[c]   = v;
    bus.din[c*W +: W]  = d;
  endtask

  task automatic idle_inputs();
    bus.din       = '0;
    bus.din_valid = '0;
    bus.q_retry   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #12;
    n_total++; if (bus.q_valid !== '0) $display("FAIL reset_q_valid got %0h exp 0", bus.q_valid); else n_pass++;
    n_total++; if (bus.din_retry !== '0) $display("FAIL reset_din_retry got %0h exp 0", bus.din_retry); else n_pass++;
    n_total++; if (bus.occ !== '0) $display("FAIL reset_occ got %0h exp 0", bus.occ); else n_pass++;
    n_total++; if (bus.drop_cnt !== '0) $display("FAIL reset_drop_cnt got %0h exp 0", bus.drop_cnt); else n_pass++;
    n_total++; if (bus.q !== '0) $display("FAIL reset_q got %0h exp 0", bus.q); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bus.q_retry[0] = 1'b1;
    drive(0, 1'b1, 16'h0011); tick();
    drive(0, 1'b1, 16'h0022); tick();
    drive(0, 1'b0, '0);
    n_total++; if (bus.occ[0 +: CW] !== CW'(2)) $display("FAIL midrst_pre_occ got %0d exp 2", bus.occ[0 +: CW]); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++; if (bus.q_valid !== '0) $display("FAIL midrst_q_valid got %0h exp 0", bus.q_valid); else n_pass++;
    n_total++; if (bus.occ !== '0) $display("FAIL midrst_occ got %0h exp 0", bus.occ); else n_pass++;
    n_total++; if (bus.din_retry !== '0) $display("FAIL midrst_din_retry got %0h exp 0", bus.din_retry); else n_pass++;
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    bus.q_retry[0] = 1'b0;
    drive(0, 1'b1, 16'h00A5);
    tick();
    drive(0, 1'b0, '0);
    n_total++; if (bus.q_valid[0] !== 1'b1) $display("FAIL midrst_a5_valid got %0b exp 1", bus.q_valid[0]); else n_pass++;
    n_total++; if (bus.q[0 +: W] !== 16'h00A5) $display("FAIL midrst_a5_data got %0h exp a5", bus.q[0 +: W]); else n_pass++;
    tick();
    n_total++; if (bus.q_valid[0] !== 1'b0) $display("FAIL midrst_drain got %0b exp 0", bus.q_valid[0]); else n_pass++;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 100; i++) begin
      drive(1, 1'b1, W'(i));
      tick();
      n_total++; if (bus.q_valid[1] !== 1'b1) $display("FAIL stream_valid[%0d] got %0b exp 1", i, bus.q_valid[1]); else n_pass++;
      n_total++; if (bus.q[W +: W] !== W'(i)) $display("FAIL stream_data[%0d] got %0h exp %0h", i, bus.q[W +: W], i); else n_pass++;
      n_total++; if (bus.occ[CW +: CW] !== CW'(1)) $display("FAIL stream_occ[%0d] got %0d exp 1", i, bus.occ[CW +: CW]); else n_pass++;
    end
    drive(1, 1'b0, '0);
    tick();
    n_total++; if (bus.q_valid[1] !== 1'b0) $display("FAIL stream_end got %0b exp 0", bus.q_valid[1]); else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.q_retry[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, W'(i));
      tick();
      n_total++; if (bus.occ[0 +: CW] !== CW'(i + 1)) $display("FAIL bp_fill_occ[%0d] got %0d exp %0d", i, bus.occ[0 +: CW], i + 1); else n_pass++;
      n_total++; if (bus.din_retry[0] !== (i == 3)) $display("FAIL bp_fill_retry[%0d] got %0b exp %0b", i, bus.din_retry[0], (i == 3)); else n_pass++;
    end
    drive(0, 1'b1, W'(4));
    tick();
    n_total++; if (bus.occ[0 +: CW] !== CW'(4)) $display("FAIL bp_blocked_occ got %0d exp 4", bus.occ[0 +: CW]); else n_pass++;
    n_total++; if (bus.q[0 +: W] !== W'(0)) $display("FAIL bp_head0 got %0h exp 0", bus.q[0 +: W]); else n_pass++;
    bus.q_retry[0] = 1'b0;
    tick();
    n_total++; if (bus.din_retry[0] !== 1'b0) $display("FAIL bp_release_retry got %0b exp 0", bus.din_retry[0]); else n_pass++;
    n_total++; if (bus.occ[0 +: CW] !== CW'(3)) $display("FAIL bp_release_occ got %0d exp 3", bus.occ[0 +: CW]); else n_pass++;
    n_total++; if (bus.q[0 +: W] !== W'(1)) $display("FAIL bp_head1 got %0h exp 1", bus.q[0 +: W]); else n_pass++;
    bus.q_retry[0] = 1'b1;
    tick();
    drive(0, 1'b0, '0);
    n_total++; if (bus.occ[0 +: CW] !== CW'(4)) $display("FAIL bp_fifth_occ got %0d exp 4", bus.occ[0 +: CW]); else n_pass++;
    n_total++; if (bus.din_retry[0] !== 1'b1) $display("FAIL bp_fifth_retry got %0b exp 1", bus.din_retry[0]); else n_pass++;
    bus.q_retry[0] = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      n_total++; if (bus.q[0 +: W] !== W'(k)) $display("FAIL bp_order[%0d] got %0h exp %0h", k, bus.q[0 +: W], k); else n_pass++;
    end
    tick();
    n_total++; if (bus.q_valid[0] !== 1'b0) $display("FAIL bp_empty got %0b exp 0", bus.q_valid[0]); else n_pass++;
  endtask

  task automatic test_drop();
    bus.q_retry[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(2, 1'b1, W'(10 + i));
      tick();
      n_total++; if (bus.din_retry[2] !== 1'b0) $display("FAIL drop_retry[%0d] got %0b exp 0", i, bus.din_retry[2]); else n_pass++;
    end
    drive(2, 1'b0, '0);
    n_total++; if (bus.drop_cnt[32 +: 16] !== 16'd2) $display("FAIL drop_cnt got %0d exp 2", bus.drop_cnt[32 +: 16]); else n_pass++;
    n_total++; if (bus.q[2*W +: W] !== W'(12)) $display("FAIL drop_head got %0d exp 12", bus.q[2*W +: W]); else n_pass++;
    n_total++; if (bus.occ[2*CW +: CW] !== CW'(4)) $display("FAIL drop_occ got %0d exp 4", bus.occ[2*CW +: CW]); else n_pass++;
    bus.q_retry[2] = 1'b0;
    for (int k = 13; k <= 15; k++) begin
      tick();
      n_total++; if (bus.q[2*W +: W] !== W'(k)) $display("FAIL drop_order[%0d] got %0d exp %0d", k, bus.q[2*W +: W], k); else n_pass++;
    end
    tick();
    n_total++; if (bus.q_valid[2] !== 1'b0) $display("FAIL drop_empty got %0b exp 0", bus.q_valid[2]); else n_pass++;
  endtask

  task automatic test_flush();
    bus.q_retry[0] = 1'b1;
    bus.q_retry[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, W'(16'h30 + i));
      drive(3, 1'b1, W'(16'h60 + i));
      tick();
    end
    n_total++; if (bus.occ[0 +: CW] !== CW'(3) || bus.occ[3*CW +: CW] !== CW'(3))
      $display("FAIL flush_pre_occ got %0d/%0d exp 3/3", bus.occ[0 +: CW], bus.occ[3*CW +: CW]); else n_pass++;
    bus.flush = 1'b1;
    drive(0, 1'b1, 16'h0077);
    drive(3, 1'b0, '0);
    bus.q_retry[3] = 1'b0;
    tick();
    bus.flush = 1'b0;
    drive(0, 1'b0, '0);
    bus.q_retry = '0;
    n_total++; if (bus.q_valid !== '0) $display("FAIL flush_q_valid got %0h exp 0", bus.q_valid); else n_pass++;
    n_total++; if (bus.occ !== '0) $display("FAIL flush_occ got %0h exp 0", bus.occ); else n_pass++;
    n_total++; if (bus.drop_cnt[32 +: 16] !== 16'd2) $display("FAIL flush_drop_cnt got %0d exp 2", bus.drop_cnt[32 +: 16]); else n_pass++;
    tick();
    n_total++; if (bus.q_valid[0] !== 1'b0) $display("FAIL flush_beat_leak got %0b exp 0", bus.q_valid[0]); else n_pass++;
  endtask

  task automatic test_isolation();
    bus.q_retry[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, W'(16'h100 + i));
      tick();
    end
    drive(0, 1'b1, 16'h01FF);
    for (int i = 0; i < 50; i++) begin
      drive(1, 1'b1, W'(16'h200 + i));
      tick();
      n_total++; if (bus.q[W +: W] !== W'(16'h200 + i)) $display("FAIL iso_ch1[%0d] got %0h exp %0h", i, bus.q[W +: W], 16'h200 + i); else n_pass++;
      n_total++; if (bus.q[0 +: W] !== 16'h0100 || bus.occ[0 +: CW] !== CW'(4))
        $display("FAIL iso_ch0[%0d] got %0h/%0d exp 100/4", i, bus.q[0 +: W], bus.occ[0 +: CW]); else n_pass++;
    end
    drive(1, 1'b0, '0);
    drive(0, 1'b0, '0);
    bus.q_retry[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++; if (bus.q[0 +: W] !== W'(16'h100 + k)) $display("FAIL iso_drain[%0d] got %0h exp %0h", k, bus.q[0 +: W], 16'h100 + k); else n_pass++;
    end
    tick();
    n_total++; if (bus.q_valid[1:0] !== 2'b00) $display("FAIL iso_empty got %0b exp 00", bus.q_valid[1:0]); else n_pass++;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < N; c++) begin
        drive(c, 1'($urandom_range(0, 3) != 0), W'($urandom));
        bus.q_retry[c] = 1'($urandom_range(0, 2) == 0);
      end
      bus.flush = ($urandom_range(0, 99) == 0);
      tick();
      for (int c = 0; c < N; c++) begin
        logic          exp_qv, exp_rt;
        logic [W-1:0]  exp_q;
        exp_qv = (mq[c].size() != 0);
        exp_q  = exp_qv ? mq[c][0] : '0;
        exp_rt = !DM[c] && (mq[c].size() == D);
        n_total++; if (bus.q_valid[c] !== exp_qv) $display("FAIL rnd_q_valid c%0d cyc%0d got %0b exp %0b", c, cyc, bus.q_valid[c], exp_qv); else n_pass++;
        n_total++; if (bus.q[c*W +: W] !== exp_q) $display("FAIL rnd_q c%0d cyc%0d got %0h exp %0h", c, cyc, bus.q[c*W +: W], exp_q); else n_pass++;
        n_total++; if (bus.din_retry[c] !== exp_rt) $display("FAIL rnd_retry c%0d cyc%0d got %0b exp %0b", c, cyc, bus.din_retry[c], exp_rt); else n_pass++;
        n_total++; if (bus.occ[c*CW +: CW] !== CW'(mq[c].size())) $display("FAIL rnd_occ c%0d cyc%0d got %0d exp %0d", c, cyc, bus.occ[c*CW +: CW], mq[c].size()); else n_pass++;
        n_total++; if (bus.drop_cnt[c*16 +: 16] !== 16'(mdrop[c])) $display("FAIL rnd_drop c%0d cyc%0d got %0d exp %0d", c, cyc, bus.drop_cnt[c*16 +: 16], mdrop[c]); else n_pass++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_streaming();
    test_backpressure();
    test_drop();
    test_flush();
    test_isolation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/scmem_chan_retime.md
# scmem_chan_retime

Parametrised multi-channel valid/retry retiming buffer for the scmem fabric. It is the generalised successor to the single-entry fflop channel stage. It provides NCHAN independent channels, each a DEPTH-entry FIFO with registered retry. Channels can be set per-channel to drop-oldest mode for lossy traffic such as prefetch requests, with a saturating drop counter. It is placed between a bank (directory, L2) and its external ports to break every combinational path between input and output handshakes.

## Interface
- WIDTH, 64: payload bits per channel.
- DEPTH, 2: entries per channel; power of two, at least 2.
- NCHAN, 4: number of independent channels.
- DROP_MASK, 0: NCHAN-bit mask; bit c=1 puts channel c in drop-oldest mode.
- CW, $clog2(DEPTH+1): derived occupancy width, not overridden.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately.
- din  in  NCHAN*WIDTH  payload; channel c at bits [c*WIDTH +: WIDTH].
- din_valid  in  NCHAN  upstream valid per channel.
- din_retry  out  NCHAN  retry to upstream per channel.
- q  out  NCHAN*WIDTH  head payload per channel.
- q_valid  out  NCHAN  head valid per channel.
- q_retry  in  NCHAN  downstream retry per channel.
- flush  in  1  synchronous, active-high; empties all channels.
- occ  out  NCHAN*CW  current occupancy per channel, 0..DEPTH.
- drop_cnt  out  NCHAN*16  count of entries discarded in drop mode; saturates at 16'hFFFF.

## Operation
- Transfer rule, both sides: a beat moves when valid=1 and retry=0 in the same cycle. Valid never depends on retry.
- push[c] = din_valid[c] & ~din_retry[c]. pop[c] = q_valid[c] & ~q_retry[c].
- Per channel state: storage[DEPTH], wr_ptr and rd_ptr of width log2(DEPTH) that wrap modulo DEPTH, count (CW bits), and drop_cnt (16 bits).
- q_valid[c] = (count != 0). q[c] = storage[rd_ptr] when q_valid=1, else 0.
- Normal channel: din_retry[c] = (count == DEPTH). On a push, write storage[wr_ptr] and advance wr_ptr. On a pop, advance rd_ptr. The count update is count + push − pop.
- Drop channel: din_retry[c] is held at 0 always.
  - If push occurs while count==DEPTH and there is no pop, overwrite the oldest entry, advance both wr_ptr and rd_ptr, leave count at DEPTH, and increment drop_cnt unless it is at 0xFFFF.
  - If push and pop occur together while full, it is a normal push+pop with no drop.
- flush=1 has priority over everything. At the next edge every channel gets wr_ptr=rd_ptr=0 and count=0.
  - A beat handshaken in a flush cycle is discarded.
  - Pops in that cycle complete at the interface; the downstream has taken the data.
  - drop_cnt is not changed by flush and is only cleared by reset.
- Channels are fully independent. Activity on channel c never affects outputs of channel k≠c.

## Timing
- Reset (reset=0): din_retry=0, q_valid=0, q=0, occ=0, drop_cnt=0, all pointers 0. Release is synchronised externally; the block's first active edge is the one after reset returns to 1.
- din_retry and q_valid are decoded from registers only. There is no combinational path from din_valid, din, or q_retry to any output.
- Latency: a push at edge t gives q_valid=1 with that payload in cycle t+1. The minimum latency is 1 cycle.
- Throughput: 1 beat per cycle per channel sustained for any DEPTH≥2, with simultaneous push and pop.
- Full (normal channel): din_retry rises the cycle after the push that makes count==DEPTH. It falls the cycle after the first pop. A push is not accepted in the cycle the pop occurs.
- Empty: q_valid falls the cycle after the pop that makes count==0. A push into an empty channel with a simultaneous q_retry is held and not lost.
- Pointer wrap: pointers roll from DEPTH−1 to 0 with no bubble.
- occ reflects count after the most recent edge.

## Test plan
- Reset mid-traffic: channel 0 holds 2 entries, then reset pulses low between edges → immediately q_valid=0, occ=0, din_retry=0; after release, push 0xA5 → q=0xA5 one cycle later.
- Streaming, DEPTH=4, q_retry=0: push 0..99 back-to-back on channel 1 → q emits 0..99 in order, one per cycle, first output 1 cycle after first push, occ never exceeds 1.
- Full/backpressure, normal channel, DEPTH=4: hold q_retry=1 and push 5 beats → 4 accepted, din_retry=1 from the cycle after the 4th; release q_retry for 1 cycle → pops entry 0, din_retry=0 next cycle, 5th beat accepted; output order is 0,1,2,3,4.
- Drop mode, DROP_MASK=4'b0100, DEPTH=2: q_retry[2]=1 and push 10,11,12,13 → din_retry[2] stays 0, drop_cnt=2, q[2]=12; release q_retry → outputs 12,13.
- Flush: channels 0 and 3 each hold 3 entries, a push on channel 0 arrives in the flush cycle → next cycle all q_valid=0 and occ=0, flushed beat never appears, drop_cnt unchanged.
- Channel isolation: channel 0 held full with q_retry=1 while channel 1 streams 50 beats → channel 1 output is complete and in order, channel 0 contents are unchanged.
